instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage for the RV32I core: owns the program counter, issues word requests to instruction memory, buffers returned instructions in a small in-order queue, and presents `{instr, pc}` with a valid/ready handshake to decode, where the immediate extender and control unit consume `instr`. Branch and jump redirects from execute flush the queue and discard stale in-flight responses.

## Interface
- `WIDTH`, 32: data and address width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `DEPTH`, 2: queue entries. This is also the maximum of queued plus outstanding requests. Power of two, at least 2.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  WIDTH  byte address of the request; bits [1:0] always 00.
- `imem_rsp_valid`  in  1  response data valid. Responses return in order, one per cycle maximum.
- `imem_rsp_data`  in  WIDTH  instruction word.
- `redirect_valid`  in  1  taken branch or jump.
- `redirect_pc`  in  WIDTH  target; bits [1:0] are ignored and forced to 00.
- `out_valid`  out  1  decode may take `out_instr`/`out_pc`.
- `out_ready`  in  1  decode accepts.
- `out_instr`  out  WIDTH  instruction; NOP 32'h0000_0013 when `out_valid`=0.
- `out_pc`  out  WIDTH  address of `out_instr`.

## Operation
- Registers:
  - `pc`: next address to request.
  - `outstanding`: accepted requests not yet responded to; range 0..DEPTH.
  - `drop_cnt`: stale responses still to discard.
  - Queue of DEPTH `{instr, pc}` entries, with `count`.
- Credit rule: `imem_req_valid` = `rst_n` && !`redirect_valid` && (`count` + `outstanding` − pop_this_cycle) < DEPTH. Combinational. `imem_addr` = `pc`.
  - A request may be withdrawn on a redirect cycle; the imem port tolerates this.
- Request accepted (`imem_req_valid` && `imem_req_ready`): `pc` += 4, wrapping modulo 2^WIDTH. `outstanding` +1.
- Response (`imem_rsp_valid`): `outstanding` −1.
  - If `drop_cnt` > 0: discard the response and decrement `drop_cnt`.
  - Otherwise: push `{imem_rsp_data, fetch_pc}`, where `fetch_pc` is a response-address register advanced by 4 on each kept response. There is always space, by the credit rule.
- Pop: `out_valid` && `out_ready` removes the head entry.
- Mode FSM:
  - RUN (`drop_cnt`=0).
  - DRAIN (`drop_cnt`>0): new requests still issue; responses are discarded until `drop_cnt` reaches 0, then RUN.
- Redirect cycle:
  - `pc` ← `redirect_pc` & ~3; `fetch_pc` ← same value.
  - Queue cleared, including any push this cycle. A pop in the same cycle completes normally.
  - `drop_cnt` ← `outstanding` − `imem_rsp_valid`, regardless of the current `drop_cnt`.
  - `outstanding` still decrements on a response this cycle.
- Back-to-back redirects: each recomputes `drop_cnt` from the current `outstanding`. The last redirect wins.
- Simultaneous push and pop with a full queue is legal only via credit: never more than DEPTH entries.

## Timing
- Reset (async assert, sync release): `pc`=RESET_PC, `outstanding`=0, `drop_cnt`=0, queue empty.
  - Outputs: `out_valid`=0, `out_instr`=NOP, `out_pc`=RESET_PC, `imem_req_valid`=0.
  - `imem_req_valid`=1 from the first cycle after release.
- Minimum latency: response in cycle N (memory answers the cycle after acceptance) → `out_valid`=1 in cycle N+1.
  - With zero-wait memory and `out_ready`=1, throughput is 1 instruction/cycle once DEPTH ≥ 2.
- Redirect in cycle N: first request to the target in cycle N+1. `out_valid`=0 in cycle N+1.
- Outputs `out_*` are registered queue-head state. No combinational path from `imem_rsp_*` to `out_*`.
- Reset mid-operation: all state clears immediately. Stale memory responses after reset release are the environment's responsibility (imem is reset together with the core).

## Structure
- `fetch_pkg`: `NOP_INSTR` = 32'h0000_0013, `PC_STEP` = 4, and the `fetch_entry_t` struct `{instr, pc}`.
- Sub-module `fetch_fifo`: a DEPTH-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count and head.
- Top level: PC, credit, drop counter and FSM. Roughly 200 lines total.

## Test plan
- **Reset and stream:** release reset; zero-wait memory returns address>>2; `out_ready`=1 → `out_pc` 0,4,8,12 on consecutive cycles with matching `instr`.
- **Backpressure:** hold `out_ready`=0 for 5 cycles → at most DEPTH=2 requests issued and `imem_req_valid`=0 thereafter. Release → pcs 0,4 then 8 with no gap or loss.
- **Redirect with 2 in flight:** memory latency 3, redirect to 0x100 while `outstanding`=2 → two responses dropped; next `out_pc`=0x100.
- **Redirect coinciding with a response:** redirect to 0x200 and `imem_rsp_valid` in the same cycle, `outstanding`=2 → `drop_cnt`=1; first delivered `out_pc`=0x200.
- **Back-to-back redirects** (0x40 then 0x80) during DRAIN → only 0x80-stream instructions appear. Misaligned `redirect_pc` 0x83 → 0x80.
- **Mid-stream reset:** assert `rst_n` low with 2 outstanding → `out_valid`=0 immediately; after release, the first `out_pc`=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0: what decode sees when no instruction is available
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive instruction words
  localparam int PC_STEP = 4;

  // One queued fetch result: the instruction word and the address it came from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // RUN keeps every response, DRAIN discards responses that predate a redirect
  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_DRAIN = 1'b1
  } fetch_mode_e;

  // Instruction addresses are word aligned; the low two bits are dropped
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue of fetched {instr, pc} entries. The head is read
// straight from the storage registers, so it carries no combinational path
// from the push side. A flush empties the queue and ignores a push in the
// same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH       = 2,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Storage, pointers and occupancy; pointers wrap because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_ENTRY;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= entry_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues word requests under a credit limit,
// queues returned instructions and hands {instr, pc} to decode. A redirect
// restarts fetch at the target and throws away responses already in flight.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam fetch_entry_t RESET_ENTRY = '{instr: NOP_INSTR, pc: RESET_PC};

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] fetchPc_q;
  logic [WIDTH-1:0] fetchPc_d;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;
  logic [CNT_W-1:0] dropCnt_q;
  logic [CNT_W-1:0] dropCnt_d;
  fetch_mode_e      state_q;
  fetch_mode_e      state_d;

  logic [CNT_W-1:0] fifoCount;
  fetch_entry_t     fifoHead;
  fetch_entry_t     pushEntry;
  logic             keepRsp;
  logic             popFire;
  logic             reqFire;
  logic [SUM_W-1:0] creditUsed;
  logic [WIDTH-1:0] redirectTarget;

  // Decode side: the head entry is only presented while the queue holds something
  assign out_valid = (fifoCount != '0);
  assign out_instr = out_valid ? fifoHead.instr : NOP_INSTR;
  assign out_pc    = fifoHead.pc;
  assign popFire   = out_valid && out_ready;

  // Queued entries plus in-flight requests may never exceed DEPTH; a pop this
  // cycle frees a slot early so a full stream keeps one request per cycle
  assign creditUsed     = SUM_W'(fifoCount) + SUM_W'(outstanding_q) - SUM_W'(popFire);
  assign imem_req_valid = rst_n && !redirect_valid && (creditUsed < SUM_W'(DEPTH));
  assign imem_addr      = pc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign redirectTarget = alignWord(redirect_pc);
  assign pushEntry      = '{instr: imem_rsp_data, pc: fetchPc_q};

  // Mode FSM next state: decide whether this response is kept or discarded,
  // and let a redirect rebuild the discard count from what is still in flight
  always_comb begin
    state_d   = state_q;
    dropCnt_d = dropCnt_q;
    keepRsp   = 1'b0;
    case (state_q)
      MODE_RUN: begin
        keepRsp = imem_rsp_valid;
      end
      MODE_DRAIN: begin
        if (imem_rsp_valid) begin
          dropCnt_d = dropCnt_q - CNT_W'(1);
          if (dropCnt_q == CNT_W'(1)) begin
            state_d = MODE_RUN;
          end
        end
      end
      default: begin
        state_d = MODE_RUN;
      end
    endcase
    if (redirect_valid) begin
      dropCnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
      state_d   = (dropCnt_d != '0) ? MODE_DRAIN : MODE_RUN;
    end
  end

  // Request PC, response PC and in-flight count; a redirect overrides both PCs
  always_comb begin
    pc_d          = pc_q;
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q;
    if (reqFire) begin
      pc_d = pc_q + WIDTH'(PC_STEP);
    end
    if (keepRsp) begin
      fetchPc_d = fetchPc_q + WIDTH'(PC_STEP);
    end
    case ({reqFire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (redirect_valid) begin
      pc_d      = redirectTarget;
      fetchPc_d = redirectTarget;
    end
  end

  // State registers for the PC, credit tracking and mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      state_q       <= MODE_RUN;
    end else begin
      pc_q          <= pc_d;
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      state_q       <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (keepRsp),
    .entry_i (pushEntry),
    .pop_i   (popFire),
    .flush_i (redirect_valid),
    .count_o (fifoCount),
    .head_o  (fifoHead)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a fixed-latency memory model answers
// each accepted request with address>>2, scenarios push the hand-derived
// {instr, pc} sequence they expect, and a monitor compares every handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } expEntry_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int        checks;
  int        errors;
  int        cycleNo;
  int        memLatency;
  int        acceptCount;
  expEntry_t sb[$];
  memReq_t   memPend[$];
  int        popLog[$];

  instr_fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Memory model: responses come back memLatency cycles after acceptance,
  // in order, carrying the word index of the requested address
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cycleNo        = 0;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (memPend.size() > 0 && memPend[0].due == cycleNo) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memPend[0].addr >> 2;
        void'(memPend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (!rst_n) begin
        memPend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        memPend.push_back('{addr: imem_addr, due: cycleNo + memLatency});
        acceptCount++;
      end
    end
  end

  // Monitor: every decode handshake must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        popLog.push_back(cycleNo);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output actual pc=%h instr=%h required=none", out_pc, out_instr);
        end else begin
          expEntry_t e;
          e = sb.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  task automatic expectEntry(input logic [31:0] pc);
    sb.push_back('{instr: pc >> 2, pc: pc});
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset at the current time, checks the idle outputs, then releases
  // reset just after a rising edge; the release cycle is cycle 0 of a scenario
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_instr", out_instr, NOP);
    checkOutput("rst_out_pc", out_pc, RESET_PC);
    checkOutput("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    acceptCount = 0;
    rst_n = 1'b1;
  endtask

  // One redirect cycle starting now; returns one cycle later with redirect low
  task automatic applyStimulus(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    checkOutput("redirect_req_withdrawn", imem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // Waits (bounded) until the monitor has consumed every expected entry, then
  // stops accepting so no unexpected entry is popped
  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=%0d entries left required=0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    acceptCount    = 0;
    memLatency     = 1;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    @(posedge clk);
    #1;

    // Reset and stream: zero-wait memory, decode always ready
    $display("[TB] scenario: reset and stream");
    memLatency = 1;
    out_ready  = 1'b1;
    popLog.delete();
    expectEntry(32'h0);
    expectEntry(32'h4);
    expectEntry(32'h8);
    expectEntry(32'hC);
    applyReset();
    #1;
    checkOutput("release_req_valid", imem_req_valid, 1'b1);
    checkOutput("release_imem_addr", imem_addr, RESET_PC);
    waitDrain("stream");
    checkOutput("stream_pop_count", popLog.size(), 4);
    if (popLog.size() > 0) checkOutput("stream_gap", popLog[$] - popLog[0], 3);

    // Backpressure: decode stalled for 5 cycles, then released
    $display("[TB] scenario: backpressure");
    memLatency = 1;
    out_ready  = 1'b0;
    applyReset();
    repeat (5) @(negedge clk);
    #1;
    checkOutput("stall_requests", acceptCount, 2);
    checkOutput("stall_req_valid", imem_req_valid, 1'b0);
    checkOutput("stall_out_valid", out_valid, 1'b1);
    popLog.delete();
    expectEntry(32'h0);
    expectEntry(32'h4);
    expectEntry(32'h8);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain("backpressure");
    checkOutput("release_pop_count", popLog.size(), 3);
    if (popLog.size() > 0) checkOutput("release_gap", popLog[$] - popLog[0], 2);
    advance(3);
    checkOutput("refill_out_valid", out_valid, 1'b1);

    // Redirect with two requests in flight (cycle 2, latency 3)
    $display("[TB] scenario: redirect with two in flight");
    memLatency = 3;
    out_ready  = 1'b1;
    applyReset();
    advance(2);
    applyStimulus(32'h100);
    checkOutput("post_redirect_out_valid", out_valid, 1'b0);
    expectEntry(32'h100);
    expectEntry(32'h104);
    waitDrain("redirect_inflight");

    // Redirect in the same cycle as a response (cycle 3, latency 3)
    $display("[TB] scenario: redirect with coincident response");
    memLatency = 3;
    out_ready  = 1'b1;
    applyReset();
    advance(3);
    applyStimulus(32'h200);
    checkOutput("coincident_out_valid", out_valid, 1'b0);
    expectEntry(32'h200);
    expectEntry(32'h204);
    waitDrain("redirect_coincident");

    // Back-to-back redirects during DRAIN; second target is misaligned
    $display("[TB] scenario: back-to-back redirects");
    memLatency = 3;
    out_ready  = 1'b1;
    applyReset();
    advance(2);
    applyStimulus(32'h40);
    applyStimulus(32'h83);
    checkOutput("b2b_imem_addr", imem_addr, 32'h80);
    expectEntry(32'h80);
    expectEntry(32'h84);
    waitDrain("redirect_b2b");

    // Mid-stream reset with two requests outstanding
    $display("[TB] scenario: mid-stream reset");
    memLatency = 3;
    out_ready  = 1'b1;
    applyReset();
    advance(2);
    checkOutput("pre_reset_imem_addr", imem_addr, 32'h8);
    applyReset();
    #1;
    checkOutput("rerelease_imem_addr", imem_addr, RESET_PC);
    expectEntry(32'h0);
    expectEntry(32'h4);
    waitDrain("midstream_reset");

    advance(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on simulation time
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
